ppg_beat_detect: RTL and testbench

Downstream consumer of the AFE4403 read-out stage. On every `afe_rdover` strobe it captures the 24-bit `led2_sub_aled2` ambient-corrected sample and smooths it with an 8-point moving average. A hysteresis peak-detector state machine runs on the smoothed stream and reports each heartbeat together with the beat-to-beat interval in samples. The outputs feed the heart-rate/display logic.

---
 rtl/ppg_pkg.sv | 18 +
 rtl/ppg_mavg.sv | 84 ++++++++
 rtl/ppg_beat_detect.sv | 155 +++++++++++++++
 tb/tb_ppg_beat_detect.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared widths and FSM encoding for the PPG beat detector.
package ppg_pkg;

  localparam int SAMPLE_W = 24;
  localparam int SUM_W    = 27;
  localparam int CNT_W    = 12;

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } beat_state_t;

  // Sign-extend a sample by one bit so hysteresis offsets never overflow.
  function automatic logic signed [SAMPLE_W:0] sext1(input logic [SAMPLE_W-1:0] v);
    return $signed({v[SAMPLE_W-1], v});
  endfunction

endpackage

// File: rtl/ppg_mavg.sv
// Sample capture and power-of-two moving average with warm-up gating.
module ppg_mavg
  import ppg_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                div_clk,
  input  logic                rst,
  input  logic                smp_vld,
  input  logic [SAMPLE_W-1:0] smp,
  output logic [SAMPLE_W-1:0] filt_data,
  output logic                filt_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = SAMPLE_W + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam logic [AVG_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [FW-1:0]       FILL_ONE = 1;
  localparam logic [FW-1:0]       FULL     = FW'(DEPTH);

  logic                       cap_vld_q, cap_vld_d;
  logic [SAMPLE_W-1:0]        cap_q, cap_d;
  logic [SAMPLE_W-1:0]        mem_q [DEPTH];
  logic [SAMPLE_W-1:0]        mem_d [DEPTH];
  logic signed [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2-1:0]        ptr_q, ptr_d;
  logic [FW-1:0]              fill_q, fill_d;
  logic [SAMPLE_W-1:0]        filt_data_q, filt_data_d;
  logic                       filt_valid_q, filt_valid_d;
  logic signed [SW-1:0]       new_ext, old_ext;

  // Capture stage, then running-sum update of the circular window.
  always_comb begin
    cap_vld_d    = smp_vld;
    cap_d        = smp_vld ? smp : cap_q;
    mem_d        = mem_q;
    sum_d        = sum_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    filt_data_d  = filt_data_q;
    filt_valid_d = 1'b0;
    new_ext      = SW'($signed(cap_q));
    old_ext      = SW'($signed(mem_q[ptr_q]));
    if (cap_vld_q) begin
      sum_d        = sum_q + new_ext - old_ext;
      mem_d[ptr_q] = cap_q;
      ptr_d        = ptr_q + PTR_ONE;
      if (fill_q != FULL) fill_d = fill_q + FILL_ONE;
      // Output only once the window holds real samples.
      if (fill_d == FULL) begin
        filt_valid_d = 1'b1;
        filt_data_d  = SAMPLE_W'(sum_d >>> AVG_LOG2);
      end
    end
  end

  // Pipeline and window state registers.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      cap_vld_q    <= 1'b0;
      cap_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sum_q        <= '0;
      ptr_q        <= '0;
      fill_q       <= '0;
      filt_data_q  <= '0;
      filt_valid_q <= 1'b0;
    end else begin
      cap_vld_q    <= cap_vld_d;
      cap_q        <= cap_d;
      mem_q        <= mem_d;
      sum_q        <= sum_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      filt_data_q  <= filt_data_d;
      filt_valid_q <= filt_valid_d;
    end
  end

  assign filt_data  = filt_data_q;
  assign filt_valid = filt_valid_q;

endmodule

// File: rtl/ppg_beat_detect.sv
// Heartbeat detector: smoothed PPG stream into a hysteresis peak tracker
// that reports beats, beat-to-beat interval and pulse loss.
module ppg_beat_detect
  import ppg_pkg::*;
#(
  parameter int                  AVG_LOG2 = 3,
  parameter logic [SAMPLE_W-1:0] HYST     = 24'd2000,
  parameter logic [CNT_W-1:0]    MIN_INT  = 12'd40,
  parameter logic [CNT_W-1:0]    MAX_INT  = 12'd500
) (
  input  logic                div_clk,
  input  logic                rst,
  input  logic                afe_rdover,
  input  logic [SAMPLE_W-1:0] led2_sub_aled2,
  output logic [SAMPLE_W-1:0] filt_data,
  output logic                filt_valid,
  output logic                beat,
  output logic [CNT_W-1:0]    beat_interval,
  output logic                interval_valid,
  output logic                pulse_lost
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [SAMPLE_W-1:0] mavg_data;
  logic                mavg_valid;

  ppg_mavg #(.AVG_LOG2(AVG_LOG2)) u_mavg (
    .div_clk    (div_clk),
    .rst        (rst),
    .smp_vld    (afe_rdover),
    .smp        (led2_sub_aled2),
    .filt_data  (mavg_data),
    .filt_valid (mavg_valid)
  );

  beat_state_t                state_q, state_d;
  logic                       seen_q, seen_d;
  logic signed [SAMPLE_W-1:0] max_q, max_d;
  logic signed [SAMPLE_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       prev_beat_q, prev_beat_d;
  logic                       beat_q, beat_d;
  logic [CNT_W-1:0]           beat_interval_q, beat_interval_d;
  logic                       interval_valid_q, interval_valid_d;
  logic                       pulse_lost_q, pulse_lost_d;

  logic signed [SAMPLE_W-1:0] fs;
  logic signed [SAMPLE_W:0]   fs_ext, max_lo, min_hi;
  logic [CNT_W-1:0]           cnt_inc;
  logic                       lost_now;
  logic                       fire;

  // Peak/trough tracking, interval counting and status flags per filtered sample.
  always_comb begin
    state_d          = state_q;
    seen_d           = seen_q;
    max_d            = max_q;
    min_d            = min_q;
    cnt_d            = cnt_q;
    prev_beat_d      = prev_beat_q;
    beat_d           = 1'b0;
    beat_interval_d  = beat_interval_q;
    interval_valid_d = interval_valid_q;
    pulse_lost_d     = pulse_lost_q;
    fire             = 1'b0;

    fs       = $signed(mavg_data);
    fs_ext   = sext1(mavg_data);
    max_lo   = sext1(max_q) - $signed({1'b0, HYST});
    min_hi   = sext1(min_q) + $signed({1'b0, HYST});
    cnt_inc  = (cnt_q >= MAX_INT) ? MAX_INT : cnt_q + CNT_ONE;
    lost_now = (cnt_inc == MAX_INT);

    if (mavg_valid) begin
      cnt_d = cnt_inc;
      if (!seen_q) begin
        seen_d  = 1'b1;
        state_d = RISE;
        max_d   = fs;
        min_d   = fs;
      end else begin
        case (state_q)
          RISE: begin
            if (fs > max_q) begin
              max_d = fs;
            end else if (fs_ext < max_lo && cnt_q >= MIN_INT) begin
              fire    = 1'b1;
              state_d = FALL;
              min_d   = fs;
            end
          end
          FALL: begin
            if (fs < min_q) begin
              min_d = fs;
            end else if (fs_ext > min_hi) begin
              state_d = RISE;
              max_d   = fs;
            end
          end
          default: state_d = RISE;
        endcase
      end

      // A beat overrides a simultaneous saturation; the interval is only
      // trusted when the previous beat was recent enough to be the same pulse.
      if (fire) begin
        beat_d           = 1'b1;
        cnt_d            = CNT_ONE;
        pulse_lost_d     = 1'b0;
        prev_beat_d      = 1'b1;
        interval_valid_d = prev_beat_q && !pulse_lost_q && !lost_now;
        if (prev_beat_q && !pulse_lost_q && !lost_now) beat_interval_d = cnt_q;
      end else if (lost_now) begin
        pulse_lost_d     = 1'b1;
        interval_valid_d = 1'b0;
      end
    end
  end

  // Detector state registers.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      state_q          <= RISE;
      seen_q           <= 1'b0;
      max_q            <= '0;
      min_q            <= '0;
      cnt_q            <= '0;
      prev_beat_q      <= 1'b0;
      beat_q           <= 1'b0;
      beat_interval_q  <= '0;
      interval_valid_q <= 1'b0;
      pulse_lost_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      seen_q           <= seen_d;
      max_q            <= max_d;
      min_q            <= min_d;
      cnt_q            <= cnt_d;
      prev_beat_q      <= prev_beat_d;
      beat_q           <= beat_d;
      beat_interval_q  <= beat_interval_d;
      interval_valid_q <= interval_valid_d;
      pulse_lost_q     <= pulse_lost_d;
    end
  end

  assign filt_data      = mavg_data;
  assign filt_valid     = mavg_valid;
  assign beat           = beat_q;
  assign beat_interval  = beat_interval_q;
  assign interval_valid = interval_valid_q;
  assign pulse_lost     = pulse_lost_q;

endmodule

// File: tb/tb_ppg_beat_detect.sv
// Scoreboard bench for ppg_beat_detect with a window/rule-level reference model.
module tb_ppg_beat_detect;

  logic        div_clk = 1'b0;
  logic        rst = 1'b1;
  logic        afe_rdover = 1'b0;
  logic [23:0] led2_sub_aled2 = '0;
  logic [23:0] filt_data;
  logic        filt_valid;
  logic        beat;
  logic [11:0] beat_interval;
  logic        interval_valid;
  logic        pulse_lost;

  always #5 div_clk = ~div_clk;

  ppg_beat_detect dut (
    .div_clk        (div_clk),
    .rst            (rst),
    .afe_rdover     (afe_rdover),
    .led2_sub_aled2 (led2_sub_aled2),
    .filt_data      (filt_data),
    .filt_valid     (filt_valid),
    .beat           (beat),
    .beat_interval  (beat_interval),
    .interval_valid (interval_valid),
    .pulse_lost     (pulse_lost)
  );

  typedef struct {
    bit beat;
    int interval;
    bit ival;
    bit lost;
  } st_t;

  int  filt_q[$];
  st_t st_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  bit  pending = 0;

  // beat statistics since the last reset
  int n_beat, n_beat100, first_ival, min_int;

  // reference model state
  int hist[$];
  bit m_seen, m_rising, m_prev, m_lost, m_ival;
  int m_max, m_min, m_cnt, m_interval;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_seen = 0; m_rising = 1; m_prev = 0; m_lost = 0; m_ival = 0;
    m_max = 0; m_min = 0; m_cnt = 0; m_interval = 0;
  endfunction

  // Average of the last eight samples, then the peak-detector rules.
  function automatic void model_sample(int x);
    longint s;
    int f, cnt_new;
    bit b;
    st_t st;
    hist.push_back(x);
    if (hist.size() > 8) void'(hist.pop_front());
    if (hist.size() < 8) return;
    s = 0;
    foreach (hist[i]) s += hist[i];
    f = int'(s >>> 3);
    filt_q.push_back(f);
    cnt_new = (m_cnt + 1 > 500) ? 500 : m_cnt + 1;
    b = 0;
    if (!m_seen) begin
      m_seen = 1; m_rising = 1; m_max = f; m_min = f;
    end else if (m_rising) begin
      if (f > m_max) m_max = f;
      else if (f < m_max - 2000 && m_cnt >= 40) b = 1;
    end else begin
      if (f < m_min) m_min = f;
      else if (f > m_min + 2000) begin m_rising = 1; m_max = f; end
    end
    if (b) begin
      m_rising = 0; m_min = f;
      if (m_prev && !m_lost && cnt_new < 500) begin
        m_interval = m_cnt; m_ival = 1;
      end else m_ival = 0;
      m_cnt = 1; m_lost = 0; m_prev = 1;
    end else begin
      m_cnt = cnt_new;
      if (cnt_new == 500) begin m_lost = 1; m_ival = 0; end
    end
    st.beat = b; st.interval = m_interval; st.ival = m_ival; st.lost = m_lost;
    st_q.push_back(st);
  endfunction

  // Monitor: filtered output compared on filt_valid, detector outputs one cycle later.
  st_t ms;
  int  me;
  always @(negedge div_clk) begin
    if (!rst) begin
      if (pending) begin
        chk("st_avail", int'(st_q.size() > 0), 1);
        if (st_q.size() > 0) begin
          ms = st_q.pop_front();
          chk("beat", int'(beat), int'(ms.beat));
          chk("beat_interval", int'(beat_interval), ms.interval);
          chk("interval_valid", int'(interval_valid), int'(ms.ival));
          chk("pulse_lost", int'(pulse_lost), int'(ms.lost));
          if (beat) begin
            n_beat++;
            if (first_ival < 0) first_ival = int'(interval_valid);
            if (interval_valid && beat_interval == 12'd100) n_beat100++;
            if (interval_valid && int'(beat_interval) < min_int) min_int = int'(beat_interval);
          end
        end
      end else begin
        chk("beat_idle", int'(beat), 0);
      end
      pending = 0;
      if (filt_valid) begin
        chk("filt_expected", int'(filt_q.size() > 0), 1);
        if (filt_q.size() > 0) begin
          me = filt_q.pop_front();
          chk("filt_data", int'($signed(filt_data)), me);
        end
        pending = 1;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge div_clk); #1; end
  endtask

  task automatic send(int x, int gap);
    afe_rdover = 1'b1;
    led2_sub_aled2 = x[23:0];
    model_sample(x);
    tick(1);
    afe_rdover = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    afe_rdover = 1'b0;
    tick(cycles);
    filt_q.delete();
    st_q.delete();
    pending = 0;
    model_reset();
    n_beat = 0; n_beat100 = 0; first_ival = -1; min_int = 4095;
    chk("rst_filt_data", int'(filt_data), 0);
    chk("rst_filt_valid", int'(filt_valid), 0);
    chk("rst_beat", int'(beat), 0);
    chk("rst_beat_interval", int'(beat_interval), 0);
    chk("rst_interval_valid", int'(interval_valid), 0);
    chk("rst_pulse_lost", int'(pulse_lost), 0);
    rst = 1'b0;
  endtask

  function automatic int tri_val(int k);
    int p;
    p = k % 100;
    return (p < 50) ? -20000 + p * 800 : 20000 - (p - 50) * 800;
  endfunction

  int x;

  initial begin
    do_reset(3);

    // warm-up with gaps between strobes
    for (int i = 0; i < 8; i++) send(8000, 2);
    tick(4);
    chk("warmup_level", int'($signed(filt_data)), 8000);

    // sign handling
    for (int i = 0; i < 16; i++) send((i % 2) ? 4096 : -4096, 0);
    tick(4);
    chk("alt_zero", int'($signed(filt_data)), 0);
    for (int i = 0; i < 8; i++) send(-7, int'($urandom_range(0, 1)));
    tick(4);
    chk("const_neg7", int'($signed(filt_data)), -7);

    // regular pulse, back-to-back strobes
    do_reset(1);
    for (int k = 0; k < 500; k++) send(tri_val(k), 0);
    tick(4);
    chk("tri_first_beat_ival", first_ival, 0);
    chk("tri_beats_ge4", int'(n_beat >= 4), 1);
    chk("tri_int100_ge3", int'(n_beat100 >= 3), 1);

    // refractory: 8-sample 3000-code bumps every 20 samples on a flat baseline
    do_reset(1);
    for (int k = 0; k < 240; k++) send((k >= 20 && k % 20 < 8) ? 3000 : 0, 0);
    tick(4);
    chk("refractory_min_int", int'(min_int >= 40), 1);

    // pulse loss then recovery
    for (int k = 0; k < 520; k++) send(0, 0);
    tick(4);
    chk("lost_flag", int'(pulse_lost), 1);
    chk("lost_ival", int'(interval_valid), 0);
    for (int k = 0; k < 300; k++) send(tri_val(k), 0);
    tick(4);
    chk("recover_lost", int'(pulse_lost), 0);
    chk("recover_ival", int'(interval_valid), 1);

    // random walk with random gaps, then full-scale random samples
    x = 0;
    for (int k = 0; k < 400; k++) begin
      x = x + int'($urandom_range(0, 8000)) - 4000;
      if (x > 4000000) x = 4000000;
      if (x < -4000000) x = -4000000;
      send(x, int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < 40; k++) begin
      x = int'($urandom_range(0, 32'h00FF_FFFF));
      if (x >= 32'h0080_0000) x = x - 32'h0100_0000;
      send(x, int'($urandom_range(0, 1)));
    end
    send(8388607, 0);
    for (int k = 0; k < 8; k++) send(-8388608, 0);

    // back-to-back then reset mid-stream, warm-up must repeat
    for (int k = 0; k < 30; k++) send(int'($urandom_range(0, 60000)) - 30000, 0);
    do_reset(1);
    for (int k = 0; k < 8; k++) send(1234, 0);
    tick(4);
    chk("rewarm_level", int'($signed(filt_data)), 1234);

    tick(10);
    chk("filt_q_drained", filt_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
